// File: rtl/reg_file_param_if.sv
// Bundles the datapath-facing signals of the parametrised register file.
// The master side drives register numbers, write data and the immediate; the slave is the file.
interface reg_file_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned IMM_W  = 6
);
  logic [ADDR_W-1:0] Read_Reg_Num_A;
  logic [ADDR_W-1:0] Read_Reg_Num_B;
  logic [ADDR_W-1:0] Write_Reg_Num;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;
  logic [IMM_W-1:0]  Immediate_Raw;
  logic              ImmSel;
  logic [DATA_W-1:0] Read_Data_A;
  logic [DATA_W-1:0] Read_Data_B;
  logic [DATA_W-1:0] Imm_Data;
  logic              Ready;

  modport master (
    output Read_Reg_Num_A, Read_Reg_Num_B, Write_Reg_Num, Write_Data, RegWrite,
    output Immediate_Raw, ImmSel,
    input  Read_Data_A, Read_Data_B, Imm_Data, Ready
  );

  modport slave (
    input  Read_Reg_Num_A, Read_Reg_Num_B, Write_Reg_Num, Write_Data, RegWrite,
    input  Immediate_Raw, ImmSel,
    output Read_Data_A, Read_Data_B, Imm_Data, Ready
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised two-read/one-write register file with write-to-read bypass, optional zero
// register, post-reset index-load sweep, and the immediate sign-extension unit.
module reg_file_param #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned IMM_W       = 6,
  parameter int unsigned IMM_SHORT_W = 3,
  parameter int unsigned ZERO_REG    = 0
) (
  input logic                 Clk,
  input logic                 Reset,
  reg_file_param_if.slave     bus
);
  localparam int unsigned NREG = 2 ** ADDR_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   init_idx_q, init_idx_d;
  logic [DATA_W-1:0] init_val;
  logic [DATA_W-1:0] reg_mem [NREG];

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == StInit) begin
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StInit;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  assign init_val = DATA_W'(init_idx_q);

  // The array has no reset; the sweep after reset is what gives it defined contents.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == StInit) begin
        reg_mem[init_idx_q[ADDR_W-1:0]] <= init_val;
      end else if (bus.RegWrite && !((ZERO_REG != 0) && (bus.Write_Reg_Num == '0))) begin
        reg_mem[bus.Write_Reg_Num] <= bus.Write_Data;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (state_q == StRun) begin
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end else if (bus.RegWrite && (bus.Write_Reg_Num == addr)) begin
        data = bus.Write_Data;
      end else begin
        data = reg_mem[addr];
      end
    end
    return data;
  endfunction

  always_comb begin
    bus.Read_Data_A = read_port(bus.Read_Reg_Num_A);
    bus.Read_Data_B = read_port(bus.Read_Reg_Num_B);
  end

  // Signed size casts sign-extend the long or short immediate field to DATA_W.
  always_comb begin
    if (bus.ImmSel) begin
      bus.Imm_Data = DATA_W'($signed(bus.Immediate_Raw));
    end else begin
      bus.Imm_Data = DATA_W'($signed(bus.Immediate_Raw[IMM_SHORT_W-1:0]));
    end
  end

  assign bus.Ready = (state_q == StRun);

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param: one instance without and one with the
// hardwired zero register, sharing clock and reset.
module tb_reg_file_param;
  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_errors;

  reg_file_param_if #(.DATA_W(8), .ADDR_W(3), .IMM_W(6)) bus0 ();
  reg_file_param_if #(.DATA_W(8), .ADDR_W(3), .IMM_W(6)) bus1 ();

  reg_file_param #(
    .DATA_W(8), .ADDR_W(3), .IMM_W(6), .IMM_SHORT_W(3), .ZERO_REG(0)
  ) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus0)
  );

  reg_file_param #(
    .DATA_W(8), .ADDR_W(3), .IMM_W(6), .IMM_SHORT_W(3), .ZERO_REG(1)
  ) u_dut_zero (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      edges++;
      if (bus0.Ready === 1'b1) break;
    end
  endtask

  task automatic write0(input logic [2:0] addr, input logic [7:0] data);
    bus0.RegWrite      = 1'b1;
    bus0.Write_Reg_Num = addr;
    bus0.Write_Data    = data;
    tick();
    bus0.RegWrite      = 1'b0;
    #1;
  endtask

  task automatic read0(input string tag, input logic [2:0] addr_a, input logic [7:0] exp_a,
                       input logic [2:0] addr_b, input logic [7:0] exp_b);
    bus0.Read_Reg_Num_A = addr_a;
    bus0.Read_Reg_Num_B = addr_b;
    #1;
    check_eq({tag, "_a"}, {24'h0, bus0.Read_Data_A}, {24'h0, exp_a});
    check_eq({tag, "_b"}, {24'h0, bus0.Read_Data_B}, {24'h0, exp_b});
  endtask

  initial begin
    int edges;
    logic [2:0] ia;
    logic [2:0] ib;
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    bus0.Read_Reg_Num_A = '0; bus0.Read_Reg_Num_B = '0; bus0.Write_Reg_Num = '0;
    bus0.Write_Data = '0; bus0.RegWrite = 1'b0; bus0.Immediate_Raw = '0; bus0.ImmSel = 1'b0;
    bus1.Read_Reg_Num_A = '0; bus1.Read_Reg_Num_B = '0; bus1.Write_Reg_Num = '0;
    bus1.Write_Data = '0; bus1.RegWrite = 1'b0; bus1.Immediate_Raw = '0; bus1.ImmSel = 1'b0;

    // Held reset: no sweep, Ready low, reads forced to zero.
    repeat (3) tick();
    check_eq("rst_ready", {31'h0, bus0.Ready}, 32'h0);
    bus0.Read_Reg_Num_A = 3'd5;
    bus0.Read_Reg_Num_B = 3'd7;
    #1;
    check_eq("rst_rd_a", {24'h0, bus0.Read_Data_A}, 32'h0);
    check_eq("rst_rd_b", {24'h0, bus0.Read_Data_B}, 32'h0);
    bus0.Immediate_Raw = 6'b100101;
    bus0.ImmSel = 1'b1;
    #1;
    check_eq("rst_imm", {24'h0, bus0.Imm_Data}, 32'hE5);

    // Init sweep takes exactly NREG edges.
    Reset = 1'b0;
    wait_ready(edges);
    check_eq("init_edges", edges, 32'd8);
    check_eq("zero_inst_ready", {31'h0, bus1.Ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      ia = 3'(i);
      ib = 3'(7 - i);
      read0("init_rd", ia, {5'h0, ia}, ib, {5'h0, ib});
    end

    // Basic write and dual read.
    write0(3'd3, 8'hAA);
    write0(3'd5, 8'h55);
    read0("wr_rd35", 3'd3, 8'hAA, 3'd5, 8'h55);
    read0("wr_rd4", 3'd4, 8'h04, 3'd4, 8'h04);

    // Same-cycle bypass on both ports, then from the array.
    bus0.RegWrite       = 1'b1;
    bus0.Write_Reg_Num  = 3'd6;
    bus0.Write_Data     = 8'h3C;
    bus0.Read_Reg_Num_A = 3'd6;
    bus0.Read_Reg_Num_B = 3'd6;
    #1;
    check_eq("byp_a", {24'h0, bus0.Read_Data_A}, 32'h3C);
    check_eq("byp_b", {24'h0, bus0.Read_Data_B}, 32'h3C);
    tick();
    bus0.RegWrite = 1'b0;
    #1;
    check_eq("byp_after", {24'h0, bus0.Read_Data_A}, 32'h3C);
    // Only one port matching: A bypasses, B reads the array.
    bus0.RegWrite       = 1'b1;
    bus0.Write_Reg_Num  = 3'd1;
    bus0.Write_Data     = 8'h9E;
    bus0.Read_Reg_Num_A = 3'd1;
    bus0.Read_Reg_Num_B = 3'd2;
    #1;
    check_eq("byp1_a", {24'h0, bus0.Read_Data_A}, 32'h9E);
    check_eq("byp1_b", {24'h0, bus0.Read_Data_B}, 32'h02);
    bus0.RegWrite = 1'b0;
    #1;
    check_eq("nowr_a", {24'h0, bus0.Read_Data_A}, 32'h01);

    // Immediates.
    bus0.Immediate_Raw = 6'b100101; bus0.ImmSel = 1'b1; #1;
    check_eq("imm_long_neg", {24'h0, bus0.Imm_Data}, 32'hE5);
    bus0.ImmSel = 1'b0; #1;
    check_eq("imm_short_neg", {24'h0, bus0.Imm_Data}, 32'hFD);
    bus0.Immediate_Raw = 6'b000011; #1;
    check_eq("imm_short_pos", {24'h0, bus0.Imm_Data}, 32'h03);
    bus0.Immediate_Raw = 6'b011010; bus0.ImmSel = 1'b1; #1;
    check_eq("imm_long_pos", {24'h0, bus0.Imm_Data}, 32'h1A);

    // Register 0 is an ordinary register without ZERO_REG.
    write0(3'd0, 8'h77);
    read0("reg0_plain", 3'd0, 8'h77, 3'd3, 8'hAA);

    // Mid-operation reset; writes during the sweep are ignored and reads stay zero.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bus0.RegWrite       = 1'b1;
    bus0.Write_Reg_Num  = 3'd2;
    bus0.Write_Data     = 8'hFF;
    bus0.Read_Reg_Num_A = 3'd2;
    bus0.Read_Reg_Num_B = 3'd3;
    #1;
    check_eq("mid_rst_ready", {31'h0, bus0.Ready}, 32'h0);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.Ready === 1'b1) break;
      check_eq("init_rd_zero", {16'h0, bus0.Read_Data_A, bus0.Read_Data_B}, 32'h0);
      tick();
      edges++;
    end
    bus0.RegWrite = 1'b0;
    #1;
    check_eq("mid_rst_edges", edges, 32'd8);
    read0("mid_rst_rd", 3'd2, 8'h02, 3'd3, 8'h03);
    read0("mid_rst_rd0", 3'd0, 8'h00, 3'd6, 8'h06);

    // ZERO_REG=1 instance: reg0 reads 0 with no bypass and drops writes.
    bus1.RegWrite       = 1'b1;
    bus1.Write_Reg_Num  = 3'd0;
    bus1.Write_Data     = 8'h77;
    bus1.Read_Reg_Num_A = 3'd0;
    bus1.Read_Reg_Num_B = 3'd4;
    #1;
    check_eq("zr_during", {24'h0, bus1.Read_Data_A}, 32'h0);
    check_eq("zr_other", {24'h0, bus1.Read_Data_B}, 32'h04);
    tick();
    bus1.RegWrite = 1'b0;
    #1;
    check_eq("zr_after", {24'h0, bus1.Read_Data_A}, 32'h0);
    bus1.RegWrite       = 1'b1;
    bus1.Write_Reg_Num  = 3'd4;
    bus1.Write_Data     = 8'hC3;
    tick();
    bus1.RegWrite = 1'b0;
    #1;
    check_eq("zr_reg4", {24'h0, bus1.Read_Data_B}, 32'hC3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
